call_return_ctrl: RTL and testbench
===================================

Name: call_return_ctrl

Overview:
- Call/return sequencer that sits directly upstream of the return-address stack in the accumulator processor.
- Takes CALL/RET/FLUSH requests from the main controller and drives the stack's en/con/data_in/clr.
- Collects the popped return address from the stack's registered data_out.
- Keeps its own occupancy count, so overflow and underflow are detected before the stack is touched.

Parameters:
width, 8, return-address width in bits; must match the stack's width.
depth, 2, log2 of stack entries (2**depth = 4 entries); must match the stack's depth.

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-low reset
call  input  1  push request; pc_in is sampled with it
ret  input  1  pop request
flush  input  1  empty the stack and clear the error flags
pc_in  input  width  return address to push
busy  output  1  high whenever the FSM is not in IDLE
done  output  1  one-cycle pulse marking request completion
ret_addr  output  width  popped return address; valid from the done pulse until the next RET completes
err_ovf  output  1  sticky: CALL attempted with the stack full
err_unf  output  1  sticky: RET attempted with the stack empty
stk_en  output  1  to stack en
stk_con  output  2  to stack con (00 push, 01 pop, 10 idle)
stk_din  output  width  to stack data_in
stk_clr  output  1  to stack clr (synchronous active-low on the stack side)
stk_dout  input  width  from stack data_out

Behaviour:
- All outputs are registered.
- Reset values (clr low, asynchronous): FSM in IDLE; count 0; busy 0; done 0; ret_addr 0; err_ovf 0; err_unf 0; stk_en 0; stk_con 10; stk_din 0.
- stk_clr resets to 0. While clr is held low, the stack is therefore cleared at each clk edge.
- stk_clr returns to 1 on the first clk edge after clr deasserts.
- count: internal, depth+1 bits, range 0..2**depth.
- Requests are sampled only in IDLE. Requests arriving while busy=1 are dropped. The controller must wait for done.
- Request priority in IDLE: flush > call > ret. Lower-priority requests in the same cycle are dropped.
- FSM states: IDLE, PUSH, POP, WAIT, CLR.
- IDLE + flush:
  - stk_clr<=0, count<=0, err_ovf<=0, err_unf<=0; go to CLR.
  - CLR: stk_clr<=1, done<=1; go to IDLE.
- IDLE + call, count==2**depth (full):
  - err_ovf<=1, done<=1; stay in IDLE.
  - Stack is not touched.
- IDLE + call, not full:
  - stk_din<=pc_in, stk_en<=1, stk_con<=00; go to PUSH.
  - PUSH (stack writes at this edge): stk_en<=0, stk_con<=10, count<=count+1, done<=1; go to IDLE.
- IDLE + ret, count==0 (empty):
  - err_unf<=1, done<=1; stay in IDLE. ret_addr unchanged.
- IDLE + ret, count>0:
  - stk_en<=1, stk_con<=01; go to POP.
  - POP (stack loads data_out at this edge): stk_en<=0, stk_con<=10, count<=count-1; go to WAIT.
  - WAIT: ret_addr<=stk_dout, done<=1; go to IDLE.
- Latency from the request edge to the done pulse:
  - CALL: 2 cycles.
  - RET: 3 cycles.
  - FLUSH: 2 cycles.
  - Rejected CALL/RET: 1 cycle.
- done is high for exactly one cycle per accepted request, including rejected ones.
- Error flags are sticky. Only flush or reset clears them. Successful operations never clear them.
- The stack is never sent a push when count==2**depth, nor a pop when count==0. Its internal full/empty quirks are never exercised.
- Reset mid-operation (any state): everything returns to reset values immediately. stk_clr=0 clears the stack, keeping count and stack contents consistent.

Test Plan:
- Reset, then CALL pc_in=8'h12, 8'h34, 8'h56, 8'h78 (each waiting for done) -> four done pulses, each 2 cycles after its request; err_ovf=0; stk_con=00 for exactly one cycle per push.
- Continue with a fifth CALL 8'h9A -> done after 1 cycle; err_ovf=1; stk_en stays 0.
- Four RETs -> ret_addr=8'h78, 8'h56, 8'h34, 8'h12, each presented with done 3 cycles after its request; a fifth RET -> err_unf=1, ret_addr stays 8'h12.
- flush with both error flags set -> stk_clr low for one cycle; done 2 cycles later; err_ovf=err_unf=0; a following RET -> err_unf=1.
- call=1 and ret=1 in the same IDLE cycle, pc_in=8'hA5, count 0 -> push only, count=1; then RET -> ret_addr=8'hA5.
- Assert clr in POP state after two CALLs -> busy=0, stk_clr=0 immediately; after release, RET -> err_unf=1.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Call/return sequencer in front of the return-address stack: tracks occupancy,
// rejects overflow/underflow before the stack sees them, and captures popped addresses.
module call_return_ctrl #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             call,
    input  logic             ret,
    input  logic             flush,
    input  logic [width-1:0] pc_in,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] ret_addr,
    output logic             err_ovf,
    output logic             err_unf,
    output logic             stk_en,
    output logic [1:0]       stk_con,
    output logic [width-1:0] stk_din,
    output logic             stk_clr,
    input  logic [width-1:0] stk_dout
);

    localparam int unsigned CNT_W = depth + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << depth);
    localparam logic [1:0] CON_PUSH = 2'b00;
    localparam logic [1:0] CON_POP  = 2'b01;
    localparam logic [1:0] CON_IDLE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PUSH = 3'd1,
        S_POP  = 3'd2,
        S_WAIT = 3'd3,
        S_CLR  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [width-1:0] ret_addr_q, ret_addr_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unf_q, err_unf_d;
    logic             stk_en_q, stk_en_d;
    logic [1:0]       stk_con_q, stk_con_d;
    logic [width-1:0] stk_din_q, stk_din_d;
    logic             stk_clr_q, stk_clr_d;

    logic full_c;
    logic empty_c;

    assign full_c  = (count_q == CNT_FULL);
    assign empty_c = (count_q == '0);

    // State and output registers; stk_clr resets low so the stack clears while clr is held.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ret_addr_q <= '0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
            stk_en_q   <= 1'b0;
            stk_con_q  <= CON_IDLE;
            stk_din_q  <= '0;
            stk_clr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ret_addr_q <= ret_addr_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
            stk_en_q   <= stk_en_d;
            stk_con_q  <= stk_con_d;
            stk_din_q  <= stk_din_d;
            stk_clr_q  <= stk_clr_d;
        end
    end

    // Next state: flush > call > ret, rejected requests stay in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (flush)                  state_d = S_CLR;
                else if (call)              state_d = full_c ? S_IDLE : S_PUSH;
                else if (ret && !empty_c)   state_d = S_POP;
                else                        state_d = S_IDLE;
            end
            S_PUSH:  state_d = S_IDLE;
            S_POP:   state_d = S_WAIT;
            S_WAIT:  state_d = S_IDLE;
            S_CLR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs and occupancy count.
    always_comb begin
        count_d    = count_q;
        done_d     = 1'b0;
        ret_addr_d = ret_addr_q;
        err_ovf_d  = err_ovf_q;
        err_unf_d  = err_unf_q;
        stk_en_d   = 1'b0;
        stk_con_d  = CON_IDLE;
        stk_din_d  = stk_din_q;
        stk_clr_d  = 1'b1;
        busy_d     = (state_d != S_IDLE);
        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    stk_clr_d = 1'b0;
                    count_d   = '0;
                    err_ovf_d = 1'b0;
                    err_unf_d = 1'b0;
                end else if (call) begin
                    if (full_c) begin
                        err_ovf_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        stk_din_d = pc_in;
                        stk_en_d  = 1'b1;
                        stk_con_d = CON_PUSH;
                    end
                end else if (ret) begin
                    if (empty_c) begin
                        err_unf_d = 1'b1;
                        done_d    = 1'b1;
                    end else begin
                        stk_en_d  = 1'b1;
                        stk_con_d = CON_POP;
                    end
                end
            end
            S_PUSH: begin
                count_d = count_q + CNT_W'(1);
                done_d  = 1'b1;
            end
            S_POP: begin
                count_d = count_q - CNT_W'(1);
            end
            S_WAIT: begin
                ret_addr_d = stk_dout;
                done_d     = 1'b1;
            end
            S_CLR: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign ret_addr = ret_addr_q;
    assign err_ovf  = err_ovf_q;
    assign err_unf  = err_unf_q;
    assign stk_en   = stk_en_q;
    assign stk_con  = stk_con_q;
    assign stk_din  = stk_din_q;
    assign stk_clr  = stk_clr_q;

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural 4-entry stack
// (registered data_out, synchronous active-low clear) attached to its stack port.
module tb_call_return_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       call, ret, flush;
    logic [7:0] pc_in;
    logic       busy, done, err_ovf, err_unf, stk_en, stk_clr;
    logic [7:0] ret_addr, stk_din, stk_dout;
    logic [1:0] stk_con;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    call_return_ctrl #(.width(8), .depth(2)) dut (
        .clk(clk), .clr(clr), .call(call), .ret(ret), .flush(flush), .pc_in(pc_in),
        .busy(busy), .done(done), .ret_addr(ret_addr), .err_ovf(err_ovf), .err_unf(err_unf),
        .stk_en(stk_en), .stk_con(stk_con), .stk_din(stk_din), .stk_clr(stk_clr),
        .stk_dout(stk_dout)
    );

    // Stack model
    logic [7:0] mem [4];
    logic [2:0] sp;
    always @(posedge clk) begin
        if (!stk_clr) begin
            sp       <= 3'd0;
            stk_dout <= 8'h00;
        end else if (stk_en && stk_con == 2'b00) begin
            mem[sp[1:0]] <= stk_din;
            sp           <= sp + 3'd1;
        end else if (stk_en && stk_con == 2'b01) begin
            stk_dout <= mem[2'(sp - 3'd1)];
            sp       <= sp - 3'd1;
        end
    end

    // Issue one request and record latency to done plus what the stack port did meanwhile.
    task automatic issue(input logic c, input logic r, input logic f, input logic [7:0] pc,
                         output int lat, output int con00, output int con01,
                         output int clr_lo, output int en_hi, output logic done_next);
        @(negedge clk);
        call = c; ret = r; flush = f; pc_in = pc;
        @(posedge clk);
        #1;
        call = 1'b0; ret = 1'b0; flush = 1'b0;
        lat = -1; con00 = 0; con01 = 0; clr_lo = 0; en_hi = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (stk_con == 2'b00) con00++;
            if (stk_con == 2'b01) con01++;
            if (!stk_clr) clr_lo++;
            if (stk_en) en_hi++;
            if (done) begin
                lat = n;
                break;
            end
        end
        @(negedge clk);
        done_next = done;
    endtask

    task automatic test_reset();
        clr = 1'b0; call = 1'b0; ret = 1'b0; flush = 1'b0; pc_in = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err_ovf, err_unf, stk_en, stk_clr} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000000", {busy, done, err_ovf, err_unf, stk_en, stk_clr});
        end
        checks++;
        if (stk_con !== 2'b10 || ret_addr !== 8'h00 || stk_din !== 8'h00) begin
            failures++;
            $display("FAIL reset_data con=%b ret_addr=%h din=%h want 10/00/00", stk_con, ret_addr, stk_din);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (stk_clr !== 1'b0) begin
            failures++;
            $display("FAIL stk_clr_before_edge got=%b want=0", stk_clr);
        end
        @(negedge clk);
        checks++;
        if (stk_clr !== 1'b1) begin
            failures++;
            $display("FAIL stk_clr_after_release got=%b want=1", stk_clr);
        end
    endtask

    task automatic test_push_fill();
        logic [7:0] pcs [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        int lat, c0, c1, cl, en;
        logic dn;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 1'b0, 1'b0, pcs[i], lat, c0, c1, cl, en, dn);
            checks++;
            if (lat != 2 || c0 != 1 || dn !== 1'b0 || err_ovf !== 1'b0) begin
                failures++;
                $display("FAIL push_%0d lat=%0d con00=%0d done_next=%b ovf=%b want 2/1/0/0", i, lat, c0, dn, err_ovf);
            end
        end
    endtask

    task automatic test_overflow();
        int lat, c0, c1, cl, en;
        logic dn;
        issue(1'b1, 1'b0, 1'b0, 8'h9A, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 1 || en != 0 || err_ovf !== 1'b1 || dn !== 1'b0) begin
            failures++;
            $display("FAIL overflow lat=%0d en=%0d ovf=%b done_next=%b want 1/0/1/0", lat, en, err_ovf, dn);
        end
    endtask

    task automatic test_pop_drain();
        logic [7:0] exp [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int lat, c0, c1, cl, en;
        logic dn;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
            checks++;
            if (lat != 3 || ret_addr !== exp[i] || c1 != 1 || dn !== 1'b0) begin
                failures++;
                $display("FAIL pop_%0d lat=%0d ret_addr=%h con01=%0d want 3/%h/1", i, lat, ret_addr, c1, exp[i]);
            end
        end
        issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 1 || err_unf !== 1'b1 || ret_addr !== 8'h12 || en != 0) begin
            failures++;
            $display("FAIL underflow lat=%0d unf=%b ret_addr=%h en=%0d want 1/1/12/0", lat, err_unf, ret_addr, en);
        end
        checks++;
        if (err_ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b want=1", err_ovf);
        end
    endtask

    task automatic test_flush();
        int lat, c0, c1, cl, en;
        logic dn;
        issue(1'b0, 1'b0, 1'b1, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 2 || cl != 1 || err_ovf !== 1'b0 || err_unf !== 1'b0 || stk_clr !== 1'b1) begin
            failures++;
            $display("FAIL flush lat=%0d clr_lo=%0d ovf=%b unf=%b want 2/1/0/0", lat, cl, err_ovf, err_unf);
        end
        issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 1 || err_unf !== 1'b1 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ret_after_flush lat=%0d unf=%b ovf=%b want 1/1/0", lat, err_unf, err_ovf);
        end
    endtask

    task automatic test_call_ret_same();
        int lat, c0, c1, cl, en;
        logic dn;
        issue(1'b1, 1'b1, 1'b0, 8'hA5, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 2 || c0 != 1 || c1 != 0 || stk_din !== 8'hA5) begin
            failures++;
            $display("FAIL call_ret_same lat=%0d con00=%0d con01=%0d din=%h want 2/1/0/a5", lat, c0, c1, stk_din);
        end
        issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 3 || ret_addr !== 8'hA5) begin
            failures++;
            $display("FAIL ret_a5 lat=%0d ret_addr=%h want 3/a5", lat, ret_addr);
        end
        issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 1 || ret_addr !== 8'hA5) begin
            failures++;
            $display("FAIL ret_empty_again lat=%0d ret_addr=%h want 1/a5", lat, ret_addr);
        end
    endtask

    task automatic test_reset_mid_pop();
        int lat, c0, c1, cl, en;
        logic dn;
        issue(1'b1, 1'b0, 1'b0, 8'h11, lat, c0, c1, cl, en, dn);
        issue(1'b1, 1'b0, 1'b0, 8'h22, lat, c0, c1, cl, en, dn);
        @(negedge clk);
        ret = 1'b1;
        @(posedge clk);
        #1;
        ret = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || stk_con !== 2'b01) begin
            failures++;
            $display("FAIL in_pop busy=%b con=%b want 1/01", busy, stk_con);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stk_clr !== 1'b0 || stk_en !== 1'b0 || stk_con !== 2'b10 || err_unf !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset busy=%b clr=%b en=%b con=%b unf=%b want 0/0/0/10/0",
                     busy, stk_clr, stk_en, stk_con, err_unf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        issue(1'b0, 1'b1, 1'b0, 8'h00, lat, c0, c1, cl, en, dn);
        checks++;
        if (lat != 1 || err_unf !== 1'b1 || en != 0) begin
            failures++;
            $display("FAIL ret_after_reset lat=%0d unf=%b en=%0d want 1/1/0", lat, err_unf, en);
        end
    endtask

    initial begin
        test_reset();
        test_push_fill();
        test_overflow();
        test_pop_drain();
        test_flush();
        test_call_ret_same();
        test_reset_mid_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
